// File: rtl/adc0809_resp_if.sv
// adc0809_resp_if
//   Bus between the game CPU side (master) and the ADC0809 model (slave).
//   Signals:
//     CE         converter clock enable, one MCLK wide
//     CH0..CH3   8-bit analog channel values (AX0, AY0, AX1, AY1)
//     ALE        address latch enable (level), latches ADDR
//     ADDR       3-bit channel select
//     START      start of conversion (level, edge-detected inside)
//     OE         output enable (level)
//     DOUT       conversion result, 8'hFF while OE=0
//     EOC        end of conversion, high = idle or done
//     state_dbg  current FSM state of the converter
//
// Handshake: the master raises START (EOC falls the next cycle) and lowers
// it; the falling edge samples the selected channel. EOC rises again when
// the result is ready, after which OE=1 puts the result on DOUT. A new START
// rising edge at any point restarts the sequence.
interface adc0809_resp_if;
  logic       CE;
  logic [7:0] CH0;
  logic [7:0] CH1;
  logic [7:0] CH2;
  logic [7:0] CH3;
  logic       ALE;
  logic [2:0] ADDR;
  logic       START;
  logic       OE;
  logic [7:0] DOUT;
  logic       EOC;
  logic [1:0] state_dbg;

  modport master (
    output CE, CH0, CH1, CH2, CH3, ALE, ADDR, START, OE,
    input  DOUT, EOC, state_dbg
  );

  modport slave (
    input  CE, CH0, CH1, CH2, CH3, ALE, ADDR, START, OE,
    output DOUT, EOC, state_dbg
  );
endinterface

// File: rtl/adc0809_resp.sv
// adc0809_resp
//   Cycle-level model of the ADC0809 converter as seen by the game CPU.
//   Conversion time is paced by CE, standing in for the 640 kHz ADC clock.
//   Ports:
//     MCLK     system clock, rising edge
//     RESET_N  asynchronous reset, active low
//     bus      adc0809_resp_if.slave (CE, CH0..CH3, ALE, ADDR, START, OE,
//              DOUT, EOC, state_dbg)
//   Parameters:
//     CONV_TICKS  CE ticks from START falling to EOC rising (2..255)
//     IDLE_VAL    result for the unconnected channels 4..7
module adc0809_resp #(
  parameter int         CONV_TICKS = 64,
  parameter logic [7:0] IDLE_VAL   = 8'h80
) (
  input logic          MCLK,
  input logic          RESET_N,
  adc0809_resp_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] LAST_TICK = 8'(CONV_TICKS - 1);

  state_t     state;
  logic       eoc_q;
  logic [7:0] res;
  logic [7:0] samp;
  logic [2:0] chsel;
  logic [7:0] cnt;
  logic       p_start;
  logic [7:0] sel_val;
  logic       start_rise;
  logic       start_fall;

  assign start_rise = bus.START & ~p_start;
  assign start_fall = ~bus.START & p_start;

  // Channel mux works off the latched select; a same-edge ALE only takes
  // effect for the next falling START edge.
  always_comb begin
    sel_val = IDLE_VAL;
    case (chsel)
      3'd0:    sel_val = bus.CH0;
      3'd1:    sel_val = bus.CH1;
      3'd2:    sel_val = bus.CH2;
      3'd3:    sel_val = bus.CH3;
      default: sel_val = IDLE_VAL;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      eoc_q   <= 1'b1;
      res     <= 8'h00;
      samp    <= 8'h00;
      chsel   <= 3'd0;
      cnt     <= 8'd0;
      p_start <= 1'b0;
    end else begin
      p_start <= bus.START;
      if (bus.ALE) chsel <= bus.ADDR;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_rise) begin
            state <= S_ARMED;
            eoc_q <= 1'b0;
          end
        end
        S_ARMED: begin
          // CE is ignored here; the count only starts once sampled.
          cnt <= 8'd0;
          if (start_fall) begin
            samp  <= sel_val;
            state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (start_rise) begin
            // Abort: restart from ARMED, the previous result stays put.
            state <= S_ARMED;
            cnt   <= 8'd0;
          end else if (bus.CE) begin
            if (cnt == LAST_TICK) begin
              res   <= samp;
              eoc_q <= 1'b1;
              state <= S_DONE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          eoc_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.EOC       = eoc_q;
  assign bus.DOUT      = bus.OE ? res : 8'hFF;
  assign bus.state_dbg = state;

endmodule
